// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared limits, widths and time record for the stopwatch datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

    localparam int MSEC_MAX = 99;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    localparam int MSEC_W = 7;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
        logic [MSEC_W-1:0] msec;
    } sw_time_t;

endpackage

`default_nettype wire

// File: rtl/stopwatch_digit_cnt.sv
// ============================================================================
// Module      : stopwatch_digit_cnt
// Description : One wrapping stage of the time chain; counts 0..MAX, carries on wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_digit_cnt #(
    parameter int MAX = 9,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] value_o,
    output logic         carry_o
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;
    logic         w_at_max;

    assign w_at_max = (value_q == W'(MAX));

    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (inc_i) begin
            value_d = w_at_max ? '0 : value_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
    assign carry_o = inc_i && w_at_max;

endmodule

`default_nettype wire

// File: rtl/stopwatch_dp.sv
// ============================================================================
// Module      : stopwatch_dp
// Description : Stopwatch datapath: 100 Hz prescaler and hh:mm:ss.cc count chain.
//               Optional lap freeze enabled by defining STOPWATCH_LAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_dp
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_runstop,
    input  logic              i_clear,
    input  logic              i_lap,
    output logic [MSEC_W-1:0] o_msec,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour,
    output logic              o_tick,
    output logic              o_lap_active
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] presc_q;
    logic [PRE_W-1:0] presc_d;
    logic             tick_q;
    logic             w_en;
    logic             w_term;

    logic             w_msec_carry;
    logic             w_sec_carry;
    logic             w_min_carry;
    logic             w_hour_unused_carry;
    sw_time_t         w_live;
    sw_time_t         w_shown;

    // Enable is sampled before the edge, so a stop coinciding with terminal count still increments.
    assign w_en   = i_runstop && !i_clear;
    assign w_term = w_en && (presc_q == PRE_LAST);

    always_comb begin
        presc_d = presc_q;
        if (i_clear) begin
            presc_d = '0;
        end else if (w_en) begin
            presc_d = w_term ? '0 : presc_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= w_term;
        end
    end

    stopwatch_digit_cnt #(.MAX(MSEC_MAX), .W(MSEC_W)) u_msec (
        .clk(clk), .rst_n(rst_n), .inc_i(w_term), .clr_i(i_clear),
        .value_o(w_live.msec), .carry_o(w_msec_carry)
    );

    stopwatch_digit_cnt #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
        .clk(clk), .rst_n(rst_n), .inc_i(w_msec_carry), .clr_i(i_clear),
        .value_o(w_live.sec), .carry_o(w_sec_carry)
    );

    stopwatch_digit_cnt #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
        .clk(clk), .rst_n(rst_n), .inc_i(w_sec_carry), .clr_i(i_clear),
        .value_o(w_live.min), .carry_o(w_min_carry)
    );

    stopwatch_digit_cnt #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
        .clk(clk), .rst_n(rst_n), .inc_i(w_min_carry), .clr_i(i_clear),
        .value_o(w_live.hour), .carry_o(w_hour_unused_carry)
    );

`ifdef STOPWATCH_LAP_EN
    logic     lap_q;
    sw_time_t snap_q;

    // Counting continues underneath a freeze; only the displayed value is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_q  <= 1'b0;
            snap_q <= '0;
        end else if (i_clear) begin
            lap_q  <= 1'b0;
            snap_q <= '0;
        end else if (i_lap) begin
            if (!lap_q) begin
                snap_q <= w_live;
                lap_q  <= 1'b1;
            end else begin
                lap_q  <= 1'b0;
            end
        end
    end

    assign w_shown      = lap_q ? snap_q : w_live;
    assign o_lap_active = lap_q;
`else
    logic w_lap_unused;

    assign w_lap_unused = i_lap;
    assign w_shown      = w_live;
    assign o_lap_active = 1'b0;
`endif

    assign o_msec = w_shown.msec;
    assign o_sec  = w_shown.sec;
    assign o_min  = w_shown.min;
    assign o_hour = w_shown.hour;
    assign o_tick = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_dp.sv
// ============================================================================
// Module      : tb_stopwatch_dp
// Description : Self-checking bench for stopwatch_dp (STOPWATCH_LAP_EN optional).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_dp;
    import stopwatch_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic runstop, clear, lap;
    logic f_runstop, f_clear, f_lap;
    logic h_inc, h_clr;

    logic [MSEC_W-1:0] o_msec, f_msec;
    logic [SEC_W-1:0]  o_sec,  f_sec;
    logic [MIN_W-1:0]  o_min,  f_min;
    logic [HOUR_W-1:0] o_hour, f_hour, h_val;
    logic              o_tick, f_tick, h_carry;
    logic              o_lap_active, f_lap_active;
    logic [23:0]       live, live_f;

    typedef struct {
        logic [23:0] val;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    assign live   = {o_hour, o_min, o_sec, o_msec};
    assign live_f = {f_hour, f_min, f_sec, f_msec};

    stopwatch_dp #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .clk(clk), .rst_n(rst_n), .i_runstop(runstop), .i_clear(clear), .i_lap(lap),
        .o_msec(o_msec), .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour),
        .o_tick(o_tick), .o_lap_active(o_lap_active)
    );

    stopwatch_dp #(.CLK_HZ(200), .TICK_HZ(100)) dut_fast (
        .clk(clk), .rst_n(rst_n), .i_runstop(f_runstop), .i_clear(f_clear), .i_lap(f_lap),
        .o_msec(f_msec), .o_sec(f_sec), .o_min(f_min), .o_hour(f_hour),
        .o_tick(f_tick), .o_lap_active(f_lap_active)
    );

    stopwatch_digit_cnt #(.MAX(HOUR_MAX), .W(HOUR_W)) hour_cnt (
        .clk(clk), .rst_n(rst_n), .inc_i(h_inc), .clr_i(h_clr),
        .value_o(h_val), .carry_o(h_carry)
    );

    function automatic logic [23:0] tpack(input int h, input int m, input int s, input int ms);
        return {h[4:0], m[5:0], s[5:0], ms[6:0]};
    endfunction

    task automatic wait_tick(input bit fast, output int lat, output bit to);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(fast ? f_tick : o_tick) && lat < 200);
        to = !(fast ? f_tick : o_tick);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; runstop = 1'b0; clear = 1'b0; lap = 1'b0;
        f_runstop = 1'b0; f_clear = 1'b0; h_inc = 1'b0; h_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (live !== 24'h0 || o_tick !== 1'b0 || o_lap_active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %h tick %b lap %b, want 0", live, o_tick, o_lap_active);
        end
        runstop = 1'b1;
        repeat (370) @(negedge clk);
        n_cmp++;
        if (live !== tpack(0, 0, 0, 37)) begin
            n_fail++;
            $display("FAIL reach_37: got %h, want %h", live, tpack(0, 0, 0, 37));
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (live !== 24'h0 || o_tick !== 1'b0 || o_lap_active !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %h tick %b lap %b, want 0", live, o_tick, o_lap_active);
        end
        @(negedge clk);
        rst_n = 1'b1; runstop = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_count_resume();
        exp_t e; int lat; bit to; bit seen;
        apply_reset();
        runstop = 1'b1;
        for (int k = 1; k <= 3; k++) sb.push_back('{tpack(0, 0, 0, k), 10});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_tick(1'b0, lat, to);
            n_cmp++;
            if (to || lat !== e.lat || live !== e.val) begin
                n_fail++;
                $display("FAIL count_tick: got %h after %0d, want %h after %0d", live, lat, e.val, e.lat);
            end
        end
        repeat (4) @(negedge clk);
        runstop = 1'b0;
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (o_tick) seen = 1'b1;
        end
        n_cmp++;
        if (live !== tpack(0, 0, 0, 3) || seen) begin
            n_fail++;
            $display("FAIL hold: got %h tick_seen %b, want %h no tick", live, seen, tpack(0, 0, 0, 3));
        end
        runstop = 1'b1;
        sb.push_back('{tpack(0, 0, 0, 4), 6});
        e = sb.pop_front();
        wait_tick(1'b0, lat, to);
        n_cmp++;
        if (to || lat !== e.lat || live !== e.val) begin
            n_fail++;
            $display("FAIL resume: got %h after %0d, want %h after %0d", live, lat, e.val, e.lat);
        end
        @(negedge clk);
        n_cmp++;
        if (o_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL tick_width: got tick %b, want 0", o_tick);
        end
        runstop = 1'b0;
    endtask

    task automatic test_clear_priority();
        exp_t e; int lat; bit to;
        apply_reset();
        runstop = 1'b1;
        repeat (29) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_cmp++;
        if (live !== 24'h0 || o_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_on_terminal: got %h tick %b, want 0 tick 0", live, o_tick);
        end
        sb.push_back('{tpack(0, 0, 0, 1), 10});
        e = sb.pop_front();
        wait_tick(1'b0, lat, to);
        n_cmp++;
        if (to || lat !== e.lat || live !== e.val) begin
            n_fail++;
            $display("FAIL after_clear_run: got %h after %0d, want %h after %0d", live, lat, e.val, e.lat);
        end
        repeat (5) @(negedge clk);
        runstop = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_cmp++;
        if (live !== 24'h0) begin
            n_fail++;
            $display("FAIL clear_stopped: got %h, want 0", live);
        end
        runstop = 1'b1;
        sb.push_back('{tpack(0, 0, 0, 1), 10});
        e = sb.pop_front();
        wait_tick(1'b0, lat, to);
        n_cmp++;
        if (to || lat !== e.lat || live !== e.val) begin
            n_fail++;
            $display("FAIL clear_prescaler: got %h after %0d, want %h after %0d", live, lat, e.val, e.lat);
        end
        runstop = 1'b0;
    endtask

    task automatic test_carry();
        exp_t e; int lat; bit to;
        f_clear = 1'b1;
        @(negedge clk);
        f_clear = 1'b0;
        f_runstop = 1'b1;
        repeat (200) @(negedge clk);
        n_cmp++;
        if (live_f !== tpack(0, 0, 1, 0) || f_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL msec_carry: got %h tick %b, want %h tick 1", live_f, f_tick, tpack(0, 0, 1, 0));
        end
        repeat (11798) @(negedge clk);
        n_cmp++;
        if (live_f !== tpack(0, 0, 59, 99) || f_lap_active !== 1'b0) begin
            n_fail++;
            $display("FAIL reach_59_99: got %h lap %b, want %h", live_f, f_lap_active, tpack(0, 0, 59, 99));
        end
        sb.push_back('{tpack(0, 1, 0, 0), 2});
        e = sb.pop_front();
        wait_tick(1'b1, lat, to);
        n_cmp++;
        if (to || lat !== e.lat || live_f !== e.val) begin
            n_fail++;
            $display("FAIL sec_carry: got %h after %0d, want %h after %0d", live_f, lat, e.val, e.lat);
        end
        f_runstop = 1'b0;
    endtask

    task automatic test_hour_wrap();
        exp_t e;
        h_clr = 1'b1;
        @(negedge clk);
        h_clr = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            h_inc = 1'b1;
            #1;
            n_cmp++;
            if (h_carry !== (k == 24)) begin
                n_fail++;
                $display("FAIL hour_carry: step %0d got %b, want %b", k, h_carry, (k == 24));
            end
            sb.push_back('{24'(k % 24), 0});
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({19'h0, h_val} !== e.val) begin
                n_fail++;
                $display("FAIL hour_value: step %0d got %0d, want %0d", k, h_val, e.val);
            end
        end
        h_inc = 1'b0;
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic test_lap();
        exp_t e; int lat; bit to;
        apply_reset();
        runstop = 1'b1;
        repeat (120) @(negedge clk);
        lap = 1'b1;
        @(negedge clk);
        lap = 1'b0;
        n_cmp++;
        if (o_lap_active !== 1'b1 || live !== tpack(0, 0, 0, 12)) begin
            n_fail++;
            $display("FAIL lap_freeze: got %h active %b, want %h active 1", live, o_lap_active, tpack(0, 0, 0, 12));
        end
        sb.push_back('{tpack(0, 0, 0, 12), 9});
        for (int k = 0; k < 29; k++) sb.push_back('{tpack(0, 0, 0, 12), 10});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_tick(1'b0, lat, to);
            n_cmp++;
            if (to || lat !== e.lat || live !== e.val) begin
                n_fail++;
                $display("FAIL lap_hold: got %h after %0d, want %h after %0d", live, lat, e.val, e.lat);
            end
        end
        lap = 1'b1;
        @(negedge clk);
        lap = 1'b0;
        n_cmp++;
        if (o_lap_active !== 1'b0 || live !== tpack(0, 0, 0, 42)) begin
            n_fail++;
            $display("FAIL lap_release: got %h active %b, want %h active 0", live, o_lap_active, tpack(0, 0, 0, 42));
        end
        lap = 1'b1; clear = 1'b1;
        @(negedge clk);
        lap = 1'b0; clear = 1'b0;
        n_cmp++;
        if (o_lap_active !== 1'b0 || live !== 24'h0) begin
            n_fail++;
            $display("FAIL lap_vs_clear: got %h active %b, want 0 active 0", live, o_lap_active);
        end
        repeat (15) @(negedge clk);
        lap = 1'b1;
        @(negedge clk);
        lap = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_cmp++;
        if (o_lap_active !== 1'b0 || live !== 24'h0) begin
            n_fail++;
            $display("FAIL clear_releases_lap: got %h active %b, want 0 active 0", live, o_lap_active);
        end
        runstop = 1'b0;
    endtask
`else
    task automatic test_lap();
        exp_t e; int lat; bit to;
        apply_reset();
        runstop = 1'b1;
        repeat (50) @(negedge clk);
        lap = 1'b1;
        @(negedge clk);
        lap = 1'b0;
        n_cmp++;
        if (o_lap_active !== 1'b0) begin
            n_fail++;
            $display("FAIL lap_ignored_active: got %b, want 0", o_lap_active);
        end
        sb.push_back('{tpack(0, 0, 0, 6), 9});
        sb.push_back('{tpack(0, 0, 0, 7), 10});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_tick(1'b0, lat, to);
            n_cmp++;
            if (to || lat !== e.lat || live !== e.val || o_lap_active !== 1'b0) begin
                n_fail++;
                $display("FAIL lap_ignored_live: got %h after %0d active %b, want %h after %0d active 0",
                         live, lat, o_lap_active, e.val, e.lat);
            end
        end
        runstop = 1'b0;
    endtask
`endif

    initial begin
        f_lap = 1'b0;
        test_reset();
        test_count_resume();
        test_clear_priority();
        test_carry();
        test_hour_wrap();
        test_lap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stopwatch_dp.md
Name: stopwatch_dp

Overview:
Stopwatch datapath that consumes the run/stop and clear levels from the stopwatch control unit. It divides the system clock to a 100 Hz tick and keeps a cascaded centisecond/second/minute/hour count. Its outputs feed the FND display mux. It is the receiving end of the control unit's o_runstop/o_clear interface.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz.
TICK_HZ, 100, count rate in Hz. DIV = CLK_HZ/TICK_HZ; CLK_HZ must be an integer multiple of TICK_HZ with DIV >= 2.

Ports:
clk  input  1  system clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
i_runstop  input  1  level: 1 = count, 0 = hold (from control unit o_runstop).
i_clear  input  1  level/pulse: synchronous clear while 1 (from control unit o_clear).
i_lap  input  1  one-cycle lap pulse; used only when STOPWATCH_LAP_EN is defined.
o_msec  output  7  centiseconds, 0..99.
o_sec  output  6  seconds, 0..59.
o_min  output  6  minutes, 0..59.
o_hour  output  5  hours, 0..23.
o_tick  output  1  registered one-cycle pulse on each centisecond increment.
o_lap_active  output  1  1 while the lap display is frozen.

Behaviour:
- Reset (rst_n=0, asynchronous): prescaler, all counters, o_tick, lap state and lap snapshot go to 0; all outputs read 0.
- Prescaler: width $clog2(DIV), counts 0..DIV-1.
  - Advances only when i_runstop=1 and i_clear=0.
  - Holds its value when i_runstop=0, so a partial interval is kept across stop/resume.
- Tick: on the edge where the prescaler is at DIV-1 and is enabled, the prescaler goes to 0 and o_msec increments on that same edge.
  - o_tick is 1 for exactly the following cycle.
  - First increment occurs DIV enabled cycles after run starts from a cleared state.
- Carry chain (all on the same edge as the tick, no extra latency):
  - msec 99->0 carries into sec.
  - sec 59->0 carries into min.
  - min 59->0 carries into hour.
  - hour 23->0 wraps with no overflow flag.
  - 23:59:59.99 plus one tick gives 00:00:00.00.
- Clear: when i_clear=1, the next edge zeroes the prescaler, all counters, o_tick and lap state.
  - Clear has priority over run and over a coincident tick.
  - Clear is honoured in both run and stop.
- i_runstop falling on the same edge as a prescaler terminal count: the increment is taken (enable is sampled before the edge).
- Counter values are never out of range. Each counter compares against its own limit, with no shared wide arithmetic.

Optional Feature:
STOPWATCH_LAP_EN
- Defined:
  - An i_lap pulse while not frozen captures the live counters into a snapshot on that edge and sets o_lap_active=1.
  - Outputs show the snapshot while counting continues underneath.
  - The next i_lap pulse clears o_lap_active; outputs show live values from the next cycle.
  - i_clear or reset also releases the freeze.
  - i_lap coincident with i_clear: clear wins and o_lap_active=0.
- Undefined: i_lap is ignored, o_lap_active is tied 0, no snapshot registers exist, outputs are always live.

Decomposition:
- Package stopwatch_pkg:
  - Limits MSEC_MAX=99, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - Widths MSEC_W=7, SEC_W=6, MIN_W=6, HOUR_W=5.
- Sub-module stopwatch_digit_cnt: parameterised by MAX and W, with inputs inc and clr, outputs value and carry (carry = inc && value==MAX). Instantiated four times in a chain.
- Prescaler and lap logic stay in the top level.

Test Plan:
- Reset: assert rst_n=0 mid-count with msec=37 -> all outputs 0 immediately (asynchronous), o_lap_active=0.
- Counting and resume (CLK_HZ=1000, TICK_HZ=100, DIV=10): i_runstop=1 from clear -> o_msec=1 after 10 clocks, o_tick pulses every 10 clocks. Stop at prescaler=4, hold 50 clocks, resume -> next increment after 6 more clocks.
- Carry chain: preload by running to 00:00:59.99, one more tick -> 00:01:00.00. From 23:59:59.99, one tick -> 00:00:00.00.
- Clear priority: i_clear=1 on a terminal-count edge with i_runstop=1 -> all counters 0, o_tick=0 next cycle. Clear with i_runstop=0 -> also zeroed.
- Lap (STOPWATCH_LAP_EN defined):
  - i_lap at msec=12 -> outputs hold 12 while running 30 ticks.
  - Second i_lap -> outputs show 42 the next cycle.
- Lap (STOPWATCH_LAP_EN undefined): i_lap pulses -> outputs stay live, o_lap_active stays 0.
